// File: rtl/spi_pkg.sv
// Shared constants and state type for the SPI responder.
package spi_pkg;
  localparam int SPI_WIDTH = 8;
  localparam int SPI_CNT_W = $clog2(SPI_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_slave_state_t;
endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus local TX/RX handshake for spi_slave.
// SPI_SLAVE_ERR_EN adds rx_ready, err_clr and the sticky error flags.
interface spi_slave_if;
  import spi_pkg::*;

  logic                 sclk;
  logic                 ss;
  logic                 mosi;
  logic                 miso;
  logic [SPI_WIDTH-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [SPI_WIDTH-1:0] rx_data;
  logic                 rx_valid;
  logic                 busy;
`ifdef SPI_SLAVE_ERR_EN
  logic                 rx_ready;
  logic                 err_clr;
  logic                 rx_overrun;
  logic                 tx_underrun;

  modport slave (
    input  sclk, ss, mosi, tx_data, tx_valid, rx_ready, err_clr,
    output miso, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun
  );
  modport master (
    output sclk, ss, mosi, tx_data, tx_valid, rx_ready, err_clr,
    input  miso, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun
  );
`else
  modport slave (
    input  sclk, ss, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, busy
  );
  modport master (
    output sclk, ss, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, busy
  );
`endif
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses derived from registered levels.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-3 responder on the system clock: one byte per SS-low frame, MSB first.
// Optional SPI_SLAVE_ERR_EN: rx_ready back-pressure plus sticky rx_overrun/tx_underrun.
//   state | meaning
//   IDLE  | SS high, miso forced low, waiting for SS fall
//   SHIFT | frame active, sampling MOSI on SCLK rise, shifting MISO on fall
//   DONE  | 8 bits received, SCLK ignored until SS rises
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);
  spi_slave_state_t       state_q, state_d;
  logic [SPI_CNT_W-1:0]   cnt_q, cnt_d;
  logic [SPI_WIDTH-1:0]   tx_buf_q, tx_buf_d;
  logic                   tx_full_q, tx_full_d;
  logic [SPI_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [SPI_WIDTH-2:0]   rx_shift_q, rx_shift_d;
  logic [SPI_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
`ifdef SPI_SLAVE_ERR_EN
  logic                   overrun_q, overrun_d;
  logic                   underrun_q, underrun_d;
`endif

  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_s, tx_load, byte_done;
  logic [SPI_WIDTH-1:0] rx_next;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.sclk),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.ss),
    .sync_o (ss_sync),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rx_next = {rx_shift_q, mosi_s};
  assign tx_load = bus.tx_valid & ~tx_full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      mosi_sync_q <= '0;
`ifdef SPI_SLAVE_ERR_EN
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
`ifdef SPI_SLAVE_ERR_EN
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    byte_done  = 1'b0;
`ifdef SPI_SLAVE_ERR_EN
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (bus.err_clr) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
`else
    rx_valid_d = 1'b0;
`endif

    if (tx_load) begin
      tx_buf_d  = bus.tx_data;
      tx_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          // Frame takes the old buffer; a byte written this same cycle stays queued.
          state_d    = SHIFT;
          cnt_d      = '0;
          tx_shift_d = tx_full_q ? tx_buf_q : '0;
          tx_full_d  = tx_load;
`ifdef SPI_SLAVE_ERR_EN
          if (!tx_full_q) underrun_d = 1'b1;
`endif
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = rx_next[SPI_WIDTH-2:0];
          cnt_d      = cnt_q + SPI_CNT_W'(1);
          if (cnt_q == SPI_CNT_W'(SPI_WIDTH - 1)) begin
            state_d   = DONE;
            byte_done = 1'b1;
          end
        end else if (sclk_fall && cnt_q != '0) begin
          tx_shift_d = {tx_shift_q[SPI_WIDTH-2:0], 1'b0};
        end
      end
      DONE: begin
        if (ss_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SPI_SLAVE_ERR_EN
    if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
    if (byte_done) begin
      if (rx_valid_q && !bus.rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = rx_next;
        rx_valid_d = 1'b1;
      end
    end
`else
    if (byte_done) begin
      rx_data_d  = rx_next;
      rx_valid_d = 1'b1;
    end
`endif
  end

  assign bus.miso     = (state_q != IDLE) ? tx_shift_q[SPI_WIDTH-1] : 1'b0;
  assign bus.tx_ready = ~tx_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = ~ss_sync;
`ifdef SPI_SLAVE_ERR_EN
  assign bus.rx_overrun  = overrun_q;
  assign bus.tx_underrun = underrun_q;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bus-functional SPI master plus rx_valid scoreboard.
module tb_spi_slave;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] mi;

  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h expected %02h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every rx_valid must match the next expected byte.
  always @(negedge clk) begin
    if (!rst && bus.rx_valid) begin
      checks++;
      if (exp_rx.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got %02h expected no rx_valid", bus.rx_data);
      end else begin
        logic [7:0] e;
        e = exp_rx.pop_front();
        if (bus.rx_data !== e) begin
          errors++;
          $display("FAIL rx_data got %02h expected %02h", bus.rx_data, e);
        end
      end
    end
  end

  task automatic load_tx(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input int nrise, output logic [7:0] got);
    logic [7:0] sh;
    sh  = mo;
    got = '0;
    @(negedge clk);
    bus.ss   = 1'b0;
    bus.sclk = 1'b0;
    bus.mosi = sh[7];
    for (int i = 0; i < nrise; i++) begin
      repeat (H) @(negedge clk);
      bus.sclk = 1'b1;
      got = {got[6:0], bus.miso};
      repeat (H) @(negedge clk);
      if (i != nrise - 1) begin
        bus.sclk = 1'b0;
        sh = {sh[6:0], 1'b0};
        bus.mosi = sh[7];
      end
    end
    bus.ss = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sclk = 1'b1; bus.ss = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
`ifdef SPI_SLAVE_ERR_EN
    bus.rx_ready = 1'b1; bus.err_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_miso", {7'd0, bus.miso}, 8'h00);
    chk("rst_tx_ready", {7'd0, bus.tx_ready}, 8'h01);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_busy", {7'd0, bus.busy}, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic exchange, tx_ready returns at frame start
    load_tx(8'hA5);
    chk("tx_ready_full", {7'd0, bus.tx_ready}, 8'h00);
    exp_rx.push_back(8'h3C);
    fork
      spi_xfer(8'h3C, 8, mi);
      begin
        repeat (6) @(negedge clk);
        chk("tx_ready_frame_start", {7'd0, bus.tx_ready}, 8'h01);
        chk("busy_in_frame", {7'd0, bus.busy}, 8'h01);
      end
    join
    chk("master_rx_a5", mi, 8'hA5);
    chk("busy_after", {7'd0, bus.busy}, 8'h00);
`ifdef SPI_SLAVE_ERR_EN
    chk("no_underrun", {7'd0, bus.tx_underrun}, 8'h00);
`endif

    // Underrun
    exp_rx.push_back(8'hFF);
    spi_xfer(8'hFF, 8, mi);
    chk("master_rx_underrun", mi, 8'h00);
`ifdef SPI_SLAVE_ERR_EN
    chk("tx_underrun_set", {7'd0, bus.tx_underrun}, 8'h01);
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
    @(negedge clk);
    chk("tx_underrun_clr", {7'd0, bus.tx_underrun}, 8'h00);
`endif

    // Back-to-back frames
    load_tx(8'h55);
    exp_rx.push_back(8'h01);
    spi_xfer(8'h01, 8, mi);
    chk("master_rx_55", mi, 8'h55);
    load_tx(8'hAA);
    exp_rx.push_back(8'h80);
    spi_xfer(8'h80, 8, mi);
    chk("master_rx_aa", mi, 8'hAA);

    // Abort after 4 rises, then full frame
    spi_xfer(8'hF0, 4, mi);
    chk("abort_rx_hold", bus.rx_data, 8'h80);
    exp_rx.push_back(8'h96);
    spi_xfer(8'h96, 8, mi);
    chk("post_abort_master", mi, 8'h00);
    chk("post_abort_rx", bus.rx_data, 8'h96);

    // Asynchronous reset mid-frame
    load_tx(8'h77);
    @(negedge clk);
    bus.ss = 1'b0; bus.sclk = 1'b0; bus.mosi = 1'b1;
    repeat (H) @(negedge clk);
    bus.sclk = 1'b1;
    repeat (H) @(negedge clk);
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_rst", {7'd0, bus.busy}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("arst_miso", {7'd0, bus.miso}, 8'h00);
    chk("arst_tx_ready", {7'd0, bus.tx_ready}, 8'h01);
    chk("arst_rx_data", bus.rx_data, 8'h00);
    chk("arst_rx_valid", {7'd0, bus.rx_valid}, 8'h00);
    chk("arst_busy", {7'd0, bus.busy}, 8'h00);
    bus.ss = 1'b1; bus.sclk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    load_tx(8'hC3);
    exp_rx.push_back(8'h5A);
    spi_xfer(8'h5A, 8, mi);
    chk("post_rst_master", mi, 8'hC3);

    // Ten rises in one frame: only first 8 bits count
    exp_rx.push_back(8'hB7);
    spi_xfer(8'hB7, 10, mi);
    chk("ten_rise_rx", bus.rx_data, 8'hB7);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 8'(exp_rx.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder paired with the `spi` master on the same bus. Runs on the system clock. Oversamples SCLK/SS/MOSI through synchronizers, shifts one byte per SS-low frame MSB-first, and presents received bytes and accepts transmit bytes over valid/ready handshakes to local logic.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `sclk`, `ss`, `mosi` (≥2).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `sclk` in 1: SPI clock from master, idles high.
- `ss` in 1: slave select, active low.
- `mosi` in 1: master out slave in.
- `miso` out 1: master in slave out.
- `tx_data` in 8: byte to return in the next frame.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: TX holding buffer empty.
- `rx_data` out 8: last complete received byte.
- `rx_valid` out 1: one-cycle pulse, `rx_data` updated.
- `busy` out 1: frame in progress (synchronized SS low).

## Operation
- Bus mode: SS and SCLK fall together at frame start; master drives MOSI on SCLK falling and samples MISO on SCLK rising. Slave samples MOSI on rising and shifts MISO on falling, MSB first, 8 bits per frame.
- TX holding buffer: `tx_valid && tx_ready` loads buffer, `tx_ready` deasserts next cycle. Writes while full are ignored.
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT on synchronized SS fall. TX shift register loads from buffer; buffer empties (`tx_ready`=1 next cycle). If the buffer is empty, loads 0x00 (underrun). Bit counter clears to 0.
- SHIFT, synchronized SCLK rise: `rx_shift <= {rx_shift[6:0], mosi_sync}`, counter +1. On the 8th rise: `rx_data` updates, `rx_valid` pulses, go DONE.
- SHIFT, SCLK fall: shifts TX register left only when counter is 1..7. The fall at counter 0 coincides with SS fall and is ignored.
- DONE: further SCLK edges are ignored. SS rise → IDLE.
- SS rise in SHIFT before 8 bits: abort to IDLE. No `rx_valid`. `rx_data` unchanged. The consumed TX byte is lost.
- `miso` = TX shift[7] while not IDLE, else 0.
- Counter is 3 bits plus a done flag. There is no wrap.
- Simultaneous SS rise and SCLK rise in the same cycle: SS wins, no sample.

## Timing
- Reset values: `miso`=0, `tx_ready`=1, `rx_data`=0x00, `rx_valid`=0, `busy`=0. State IDLE, buffers cleared.
- Edge detect latency: SYNC_STAGES+1 clk from pin edge to action.
- `rx_valid` asserts SYNC_STAGES+1 clk after the 8th SCLK rise at the pin.
- `miso` changes SYNC_STAGES+1 clk after an SCLK fall. The master requires SCLK half-period ≥ SYNC_STAGES+2 clk, i.e. master `clk_divisor` ≥ 8 at default.
- `busy` follows synchronized SS, lag SYNC_STAGES clk.
- A buffer load in the same cycle as the frame-start load: the frame takes the old buffer contents (0x00 if empty). The new byte waits in the buffer.

## Configuration
- `SPI_SLAVE_ERR_EN` defined: adds outputs `rx_overrun` and `tx_underrun` (1-bit, sticky, reset 0, cleared by 1-cycle input `err_clr`).
  - `rx_overrun` sets when a byte completes while the previous `rx_valid` was not acknowledged. This also adds input `rx_ready`; `rx_data` is held until `rx_ready`.
  - `tx_underrun` sets when a frame starts with the buffer empty.
- Undefined: no such ports. `rx_data` is overwritten each frame and underruns are silent.

## Structure
- Package `spi_pkg`:
  - `SPI_WIDTH`=8
  - bit-counter width
  - state enum `spi_slave_state_t` {IDLE, SHIFT, DONE}
- Sub-module `spi_sync_edge`: SYNC_STAGES-flop synchronizer with registered rise/fall pulses. Instantiated for `sclk` and `ss`; `mosi` uses synchronizer output only.

## Test plan
- Paired with master (`clk_divisor`=8), slave TX buffer 0xA5, master sends 0x3C → slave `rx_data`=0x3C with one `rx_valid` pulse; master `data_out`=0xA5; `tx_ready` returns 1 at frame start.
- Empty TX buffer, master sends 0xFF → master receives 0x00, slave `rx_data`=0xFF. With `SPI_SLAVE_ERR_EN`, `tx_underrun`=1.
- Back-to-back frames 0x01, 0x80 with TX 0x55 then 0xAA loaded between frames → `rx_valid` twice, received 0x01/0x80, master gets 0x55/0xAA.
- SS deasserted after 4 SCLK rises → no `rx_valid`, `rx_data` keeps prior value, next full frame 0x96 received correctly.
- `rst` asserted mid-frame (asynchronous, between clk edges) → outputs at reset values immediately. The frame after SS re-falls completes normally.
- 10 SCLK rises in one frame → exactly one `rx_valid`, data = first 8 bits.
